vr16_fetch_decode: RTL and testbench
====================================

Name: vr16_fetch_decode

Overview:
- Front end of the VR16 16-bit RISC core: program counter, synchronous instruction memory and field decoder, in one block on a single clock.
- The PC addresses the instruction memory.
- The fetched 16-bit word is registered and split into opcode, register and immediate fields for the execute stage.
- Supports jumps and returns via a saved return address.

Parameters:
- IMEM_DEPTH, 256, number of 16-bit instruction words; power of two; address = low log2(IMEM_DEPTH) bits of PC.
- RAS_DEPTH, 4, return-address-stack entries (used only with VR16_RAS_EN).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- jump_enable  input  1  load PC with jump_address this cycle.
- jump_address  input  16  jump target.
- return_enable  input  1  load PC with saved return address.
- imem_enable  input  1  fetch enable; 0 holds instruction.
- imem_we  input  1  instruction-memory write strobe (program load).
- imem_waddr  input  16  write address (low bits used).
- imem_wdata  input  16  write data.
- counter_reg  output  16  current PC.
- instruction  output  16  fetched word.
- opcode  output  4  instruction[15:12], registered.
- reg_a  output  4  instruction[11:8], registered.
- reg_b  output  4  instruction[7:4], registered.
- reg_c  output  4  instruction[3:0], registered.
- reg_d  output  4  destination = instruction[11:8], registered.
- imm_value  output  4  instruction[3:0], registered.

Behaviour:
- Reset (reset=0 at clk edge): counter_reg=0x0000, instruction=0x0000, all decode outputs=0, return state cleared (register=0 / stack empty). Memory contents are not cleared. Reset overrides all other inputs.
- PC priority per cycle: jump_enable > return_enable > increment.
  - Jump: PC<=jump_address; save counter_reg+1 as the return address.
  - Return: PC<=saved return address.
  - Otherwise: PC<=PC+1, modulo 2^16 (0xFFFF -> 0x0000).
- Jump and return asserted together: jump wins; no pop occurs; the push still occurs.
- Instruction memory:
  - Synchronous read: if imem_enable, instruction<=mem[PC mod IMEM_DEPTH] on clk edge; else instruction holds.
  - Synchronous write when imem_we.
  - Read and write to the same address in the same cycle returns the old data.
- Decoder: on each clk edge, all field outputs are registered from the current instruction; fields update every cycle regardless of imem_enable.
- Latency:
  - counter_reg=N at edge k -> instruction=mem[N] after edge k+1.
  - Fields after edge k+2.
- Fields are pure bit slices; no opcode-dependent gating.

Optional Feature:
- VR16_RAS_EN defined:
  - Return addresses are held in a RAS_DEPTH-entry stack. Jump pushes; return pops.
  - Push when full overwrites the oldest entry (circular).
  - Pop when empty loads PC=0x0000 and the stack stays empty.
- Undefined:
  - A single return register; each jump overwrites it.
  - Return loads PC from it and leaves it unchanged.

Test Plan:
- Reset: hold reset=0 two cycles with jump_enable=1 -> counter_reg=0x0000, instruction=0x0000, opcode..imm_value all 0.
- Sequential fetch/decode: preload mem[0..2]=0x1234,0x5678,0x9ABC; release reset, imem_enable=1.
  - counter_reg steps 0,1,2.
  - instruction=0x1234 one cycle after PC=0.
  - Two cycles after PC=0: opcode=1, reg_a=2, reg_b=3, reg_c=4, reg_d=2, imm_value=4.
- Fetch disable: imem_enable=0 with instruction=0x5678 -> instruction stays 0x5678 while counter_reg keeps incrementing.
- Jump/return: at counter_reg=0x0005, jump_enable=1, jump_address=0x0040 -> next PC=0x0040. Two cycles later return_enable=1 -> PC=0x0006.
- Simultaneous jump+return at PC=0x0010 with jump_address=0x0080 -> PC=0x0080; a later return goes to 0x0011.
- Wrap: jump to 0xFFFF, then idle -> PC=0x0000; fetch address wraps to mem[0xFF] then mem[0x00] with IMEM_DEPTH=256.
- With VR16_RAS_EN: five nested jumps from PCs 1,3,5,7,9 -> returns yield 10,8,6,4; the fifth return yields 0x0000.

Source files
------------

// File: rtl/vr16_fetch_decode.sv
// VR16 front end: program counter, synchronous instruction memory and field decoder.
// Define VR16_RAS_EN to replace the single return register with a RAS_DEPTH-entry return stack.
module vr16_fetch_decode #(
    parameter int IMEM_DEPTH = 256,
    parameter int RAS_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_enable,
    input  logic [15:0] jump_address,
    input  logic        return_enable,
    input  logic        imem_enable,
    input  logic        imem_we,
    input  logic [15:0] imem_waddr,
    input  logic [15:0] imem_wdata,
    output logic [15:0] counter_reg,
    output logic [15:0] instruction,
    output logic [3:0]  opcode,
    output logic [3:0]  reg_a,
    output logic [3:0]  reg_b,
    output logic [3:0]  reg_c,
    output logic [3:0]  reg_d,
    output logic [3:0]  imm_value
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic [15:0] mem [IMEM_DEPTH];
    logic [15:0] ret_addr;
    logic [15:0] pc_next;
    logic [15:0] pc_inc;

    assign pc_inc = counter_reg + 16'd1;

`ifdef VR16_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [15:0]   ras [RAS_DEPTH];
    logic [PW-1:0] top;
    logic [PW-1:0] top_inc;
    logic [PW-1:0] top_dec;
    logic [CW-1:0] cnt;
    logic          unused;

    assign top_inc  = (top == PW'(RAS_DEPTH - 1)) ? '0 : top + PW'(1);
    assign top_dec  = (top == '0) ? PW'(RAS_DEPTH - 1) : top - PW'(1);
    // Popping an empty stack yields address zero.
    assign ret_addr = (cnt == '0) ? 16'h0000 : ras[top];
    assign unused   = ^{imem_waddr[15:AW], counter_reg[15:AW]};

    // Entries need no reset: cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (reset && jump_enable)
            ras[top_inc] <= pc_inc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            top <= '0;
            cnt <= '0;
        end else if (jump_enable) begin
            // A full stack wraps onto its oldest entry.
            top <= top_inc;
            if (cnt != CW'(RAS_DEPTH))
                cnt <= cnt + CW'(1);
        end else if (return_enable && cnt != '0) begin
            top <= top_dec;
            cnt <= cnt - CW'(1);
        end
    end
`else
    logic unused;

    assign unused = ^{imem_waddr[15:AW], counter_reg[15:AW], RAS_DEPTH[0]};

    always_ff @(posedge clk) begin
        if (!reset)
            ret_addr <= 16'h0000;
        else if (jump_enable)
            ret_addr <= pc_inc;
    end
`endif

    always_comb begin
        pc_next = pc_inc;
        if (jump_enable)
            pc_next = jump_address;
        else if (return_enable)
            pc_next = ret_addr;
    end

    // Program load is independent of reset so memory can be filled while held in reset.
    always_ff @(posedge clk) begin
        if (imem_we)
            mem[imem_waddr[AW-1:0]] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_reg <= 16'h0000;
            instruction <= 16'h0000;
            opcode      <= 4'h0;
            reg_a       <= 4'h0;
            reg_b       <= 4'h0;
            reg_c       <= 4'h0;
            reg_d       <= 4'h0;
            imm_value   <= 4'h0;
        end else begin
            counter_reg <= pc_next;
            if (imem_enable)
                instruction <= mem[counter_reg[AW-1:0]];
            opcode    <= instruction[15:12];
            reg_a     <= instruction[11:8];
            reg_b     <= instruction[7:4];
            reg_c     <= instruction[3:0];
            reg_d     <= instruction[11:8];
            imm_value <= instruction[3:0];
        end
    end
endmodule

// File: tb/tb_vr16_fetch_decode.sv
// Self-checking bench for vr16_fetch_decode: directed scenarios plus randomized traffic
// checked against a queue/array reference model (honours VR16_RAS_EN).
module tb_vr16_fetch_decode;
    localparam int DEPTH = 256;
    localparam int RDEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        jump_enable = 1'b0;
    logic [15:0] jump_address = '0;
    logic        return_enable = 1'b0;
    logic        imem_enable = 1'b0;
    logic        imem_we = 1'b0;
    logic [15:0] imem_waddr = '0;
    logic [15:0] imem_wdata = '0;
    logic [15:0] counter_reg, instruction;
    logic [3:0]  opcode, reg_a, reg_b, reg_c, reg_d, imm_value;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_pc = '0;
    logic [15:0] m_instr = '0;
    logic [15:0] m_dec = '0;
    logic [15:0] m_ret = '0;
    logic [15:0] m_ras [$];

    vr16_fetch_decode #(.IMEM_DEPTH(DEPTH), .RAS_DEPTH(RDEPTH)) dut (
        .clk(clk), .reset(reset), .jump_enable(jump_enable), .jump_address(jump_address),
        .return_enable(return_enable), .imem_enable(imem_enable), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .counter_reg(counter_reg),
        .instruction(instruction), .opcode(opcode), .reg_a(reg_a), .reg_b(reg_b),
        .reg_c(reg_c), .reg_d(reg_d), .imm_value(imm_value)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [15:0] ret_val;
        if (!reset) begin
            m_pc = 0; m_instr = 0; m_dec = 0; m_ret = 0;
            m_ras.delete();
        end else begin
            m_dec = m_instr;
            if (imem_enable) m_instr = m_mem[int'(m_pc) % DEPTH];
`ifdef VR16_RAS_EN
            if (m_ras.size() == 0) ret_val = 16'h0000;
            else ret_val = m_ras[m_ras.size() - 1];
`else
            ret_val = m_ret;
`endif
            if (jump_enable) begin
`ifdef VR16_RAS_EN
                m_ras.push_back(16'((int'(m_pc) + 1) % 65536));
                if (m_ras.size() > RDEPTH) void'(m_ras.pop_front());
`else
                m_ret = 16'((int'(m_pc) + 1) % 65536);
`endif
                m_pc = jump_address;
            end else if (return_enable) begin
`ifdef VR16_RAS_EN
                if (m_ras.size() != 0) void'(m_ras.pop_back());
`endif
                m_pc = ret_val;
            end else begin
                m_pc = 16'((int'(m_pc) + 1) % 65536);
            end
        end
        if (imem_we) m_mem[int'(imem_waddr) % DEPTH] = imem_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; jump_enable = 1'b1; jump_address = 16'h1234; imem_enable = 1'b1;
        imem_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            imem_waddr = 16'(i);
            imem_wdata = (i == 0) ? 16'h1234 : (i == 1) ? 16'h5678 : (i == 2) ? 16'h9ABC
                                             : 16'($urandom);
            tick();
        end
        imem_we = 1'b0;
        tick(); tick();
        n_checks++;
        if (counter_reg !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", counter_reg); end
        n_checks++;
        if (instruction !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", instruction); end
        n_checks++;
        if ({opcode, reg_a, reg_b, reg_c, reg_d, imm_value} !== 24'h0) begin
            n_fail++; $display("FAIL reset_fields got %h want 000000", {opcode, reg_a, reg_b, reg_c, reg_d, imm_value});
        end
    endtask

    task automatic test_seq_fetch();
        jump_enable = 1'b0; imem_enable = 1'b1; reset = 1'b1;
        tick();
        n_checks++;
        if (counter_reg !== 16'h0001 || instruction !== 16'h1234) begin
            n_fail++; $display("FAIL seq_edge1 got pc=%h instr=%h want pc=0001 instr=1234", counter_reg, instruction);
        end
        tick();
        n_checks++;
        if (counter_reg !== 16'h0002 || instruction !== 16'h5678) begin
            n_fail++; $display("FAIL seq_edge2 got pc=%h instr=%h want pc=0002 instr=5678", counter_reg, instruction);
        end
        n_checks++;
        if ({opcode, reg_a, reg_b, reg_c, reg_d, imm_value} !== 24'h123424) begin
            n_fail++; $display("FAIL seq_fields got %h want 123424", {opcode, reg_a, reg_b, reg_c, reg_d, imm_value});
        end
    endtask

    task automatic test_fetch_disable();
        imem_enable = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            tick();
            n_checks++;
            if (instruction !== 16'h5678 || counter_reg !== 16'(i)) begin
                n_fail++; $display("FAIL fetch_hold got pc=%h instr=%h want pc=%h instr=5678", counter_reg, instruction, 16'(i));
            end
        end
        n_checks++;
        if (opcode !== 4'h5 || reg_d !== 4'h6 || imm_value !== 4'h8) begin
            n_fail++; $display("FAIL hold_fields got op=%h rd=%h imm=%h want 5 6 8", opcode, reg_d, imm_value);
        end
        imem_enable = 1'b1;
    endtask

    task automatic test_jump_return();
        jump_enable = 1'b1; jump_address = 16'h0040;
        tick();
        n_checks++;
        if (counter_reg !== 16'h0040) begin n_fail++; $display("FAIL jump_pc got %h want 0040", counter_reg); end
        jump_enable = 1'b0;
        tick();
        return_enable = 1'b1;
        tick();
        return_enable = 1'b0;
        n_checks++;
        if (counter_reg !== 16'h0006) begin n_fail++; $display("FAIL return_pc got %h want 0006", counter_reg); end
    endtask

    task automatic test_jump_and_return();
        jump_enable = 1'b1; jump_address = 16'h0010;
        tick();
        return_enable = 1'b1; jump_address = 16'h0080;
        tick();
        n_checks++;
        if (counter_reg !== 16'h0080) begin n_fail++; $display("FAIL both_pc got %h want 0080", counter_reg); end
        jump_enable = 1'b0; return_enable = 1'b0;
        tick();
        return_enable = 1'b1;
        tick();
        return_enable = 1'b0;
        n_checks++;
        if (counter_reg !== 16'h0011) begin n_fail++; $display("FAIL both_ret got %h want 0011", counter_reg); end
    endtask

    task automatic test_wrap();
        imem_we = 1'b1; imem_waddr = 16'h00FF; imem_wdata = 16'hBEEF;
        jump_enable = 1'b1; jump_address = 16'hFFFF;
        tick();
        imem_we = 1'b0; jump_enable = 1'b0;
        n_checks++;
        if (counter_reg !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_jump got %h want ffff", counter_reg); end
        tick();
        n_checks++;
        if (counter_reg !== 16'h0000 || instruction !== 16'hBEEF) begin
            n_fail++; $display("FAIL wrap_edge got pc=%h instr=%h want 0000 beef", counter_reg, instruction);
        end
        tick();
        n_checks++;
        if (counter_reg !== 16'h0001 || instruction !== 16'h1234) begin
            n_fail++; $display("FAIL wrap_mem0 got pc=%h instr=%h want 0001 1234", counter_reg, instruction);
        end
    endtask

    task automatic test_rw_collision();
        logic [15:0] p, old;
        p = m_pc; old = m_mem[int'(p) % DEPTH];
        imem_we = 1'b1; imem_waddr = p; imem_wdata = 16'hA5A5;
        tick();
        imem_we = 1'b0;
        n_checks++;
        if (instruction !== old) begin n_fail++; $display("FAIL rw_old got %h want %h", instruction, old); end
        jump_enable = 1'b1; jump_address = p;
        tick();
        jump_enable = 1'b0;
        tick();
        n_checks++;
        if (instruction !== 16'hA5A5) begin n_fail++; $display("FAIL rw_new got %h want a5a5", instruction); end
    endtask

    task automatic test_nested_returns();
        logic [15:0] exp [5];
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        jump_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jump_address = (i == 4) ? 16'h0100 : 16'(2 * i + 3);
            tick();
        end
        jump_enable = 1'b0; return_enable = 1'b1;
`ifdef VR16_RAS_EN
        exp = '{16'd10, 16'd8, 16'd6, 16'd4, 16'd0};
`else
        exp = '{16'd10, 16'd10, 16'd10, 16'd10, 16'd10};
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (counter_reg !== exp[i]) begin
                n_fail++; $display("FAIL nested_ret%0d got %h want %h", i, counter_reg, exp[i]);
            end
        end
        return_enable = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 63) != 0);
            jump_enable = ($urandom_range(0, 5) == 0);
            return_enable = ($urandom_range(0, 4) == 0);
            jump_address = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
            imem_enable = ($urandom_range(0, 3) != 0);
            imem_we = ($urandom_range(0, 3) == 0);
            imem_waddr = $urandom_range(0, 1) ? m_pc : 16'($urandom);
            imem_wdata = 16'($urandom);
            tick();
            n_checks++;
            if (counter_reg !== m_pc || instruction !== m_instr) begin
                n_fail++; $display("FAIL rand_pc_instr c=%0d got %h/%h want %h/%h", c, counter_reg, instruction, m_pc, m_instr);
            end
            n_checks++;
            if ({opcode, reg_a, reg_b, reg_c, reg_d, imm_value} !==
                {m_dec[15:12], m_dec[11:8], m_dec[7:4], m_dec[3:0], m_dec[11:8], m_dec[3:0]}) begin
                n_fail++; $display("FAIL rand_fields c=%0d got %h want dec of %h", c,
                                   {opcode, reg_a, reg_b, reg_c, reg_d, imm_value}, m_dec);
            end
        end
        reset = 1'b1; jump_enable = 1'b0; return_enable = 1'b0; imem_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_fetch_disable();
        test_jump_return();
        test_jump_and_return();
        test_wrap();
        test_rw_collision();
        test_nested_returns();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
